// File: rtl/frame_sync_pkg.sv
// Shared framing constants and types for the 64-bit Hamming-link frame
// format, used by both the transmit-side inserter and the receive-side
// synchronizer.
package frame_sync_pkg;

  localparam int          FRAME_LEN    = 64;
  localparam int          HEAD_LEN     = 8;
  localparam logic [7:0]  HEAD_PATTERN = 8'b01111110;

  // Position of a bit inside a frame, 0..FRAME_LEN-1
  typedef logic [5:0] bit_idx_t;

  localparam bit_idx_t HEAD_LAST_IDX  = bit_idx_t'(HEAD_LEN - 1);
  localparam bit_idx_t FRAME_LAST_IDX = bit_idx_t'(FRAME_LEN - 1);

  // Transmitter state encodings, visible on the tx_state port
  typedef enum logic [1:0] {
    TX_IDLE    = 2'b00,
    TX_HEAD    = 2'b01,
    TX_PAYLOAD = 2'b10
  } tx_state_e;

endpackage

// File: rtl/byte_hold_skid.sv
// One-byte hold register between the Hamming encoder and the framer.
// A byte can be accepted on the same edge the held byte is consumed; the
// new byte then waits in the hold for the next byte slot.
module byte_hold_skid
  import frame_sync_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] din_i,
  input  logic       dinValid_i,
  input  logic       consume_i,
  output logic       dinReady_o,
  output logic       holdValid_o,
  output logic [7:0] holdData_o
);

  logic       holdValid_q, holdValid_d;
  logic [7:0] holdData_q, holdData_d;
  logic       accept;

  assign dinReady_o  = !holdValid_q || consume_i;
  assign accept      = dinValid_i && dinReady_o;
  assign holdValid_o = holdValid_q;
  assign holdData_o  = holdData_q;

  // Next hold contents: consumption empties it, a transfer refills it
  always_comb begin
    holdValid_d = holdValid_q;
    holdData_d  = holdData_q;
    if (consume_i) begin
      holdValid_d = 1'b0;
    end
    if (accept) begin
      holdValid_d = 1'b1;
      holdData_d  = din_i;
    end
  end

  // Hold register, emptied by reset so a mid-frame reset drops the byte
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      holdValid_q <= 1'b0;
      holdData_q  <= 8'h00;
    end else begin
      holdValid_q <= holdValid_d;
      holdData_q  <= holdData_d;
    end
  end

endmodule

// File: rtl/frame_head_inserter.sv
// Transmit-side framer: serialises an 8-bit head followed by seven payload
// bytes per 64-bit frame, one bit per clock, MSB first. Missing payload
// bytes are replaced by FILL_BYTE and flagged with an underrun pulse.
module frame_head_inserter
  import frame_sync_pkg::*;
#(
  parameter logic [7:0] FILL_BYTE = 8'h00
) (
  input  logic        clk_out,
  input  logic        rst,
  input  logic        enable,
  input  logic [7:0]  din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic        data_out,
  output logic [5:0]  bit_index,
  output logic        frame_start,
  output logic        underrun,
  output logic [1:0]  tx_state,
  output logic [15:0] frame_cnt
);

  tx_state_e   state_q, state_d;
  bit_idx_t    bitIdx_q, bitIdx_d;
  logic [7:0]  shift_q, shift_d;
  logic        dataOut_q, dataOut_d;
  logic        frameStart_q, frameStart_d;
  logic        underrun_q, underrun_d;
  logic [15:0] frameCnt_q, frameCnt_d;

  logic        holdValid;
  logic [7:0]  holdData;
  logic        consume;
  logic        loadHead;
  logic        loadByte;
  logic [7:0]  nextByte;

  byte_hold_skid u_hold (
    .clk_i       (clk_out),
    .rst_i       (rst),
    .din_i       (din),
    .dinValid_i  (din_valid),
    .consume_i   (consume),
    .dinReady_o  (din_ready),
    .holdValid_o (holdValid),
    .holdData_o  (holdData)
  );

  // Next state, bit position and serial bit; head and payload bytes both
  // pass through the same shift register, loaded at each byte boundary
  always_comb begin
    state_d      = state_q;
    bitIdx_d     = bitIdx_q;
    shift_d      = shift_q;
    dataOut_d    = 1'b0;
    frameStart_d = 1'b0;
    underrun_d   = 1'b0;
    frameCnt_d   = frameCnt_q;
    consume      = 1'b0;
    loadHead     = 1'b0;
    loadByte     = 1'b0;
    nextByte     = 8'h00;

    case (state_q)
      TX_IDLE: begin
        bitIdx_d = '0;
        shift_d  = 8'h00;
        if (enable) begin
          state_d      = TX_HEAD;
          loadHead     = 1'b1;
          frameStart_d = 1'b1;
        end
      end
      TX_HEAD: begin
        bitIdx_d = bitIdx_q + 6'd1;
        if (bitIdx_q == HEAD_LAST_IDX) begin
          state_d  = TX_PAYLOAD;
          loadByte = 1'b1;
        end
      end
      TX_PAYLOAD: begin
        if (bitIdx_q == FRAME_LAST_IDX) begin
          frameCnt_d = frameCnt_q + 16'd1;
          bitIdx_d   = '0;
          if (enable) begin
            state_d      = TX_HEAD;
            loadHead     = 1'b1;
            frameStart_d = 1'b1;
          end else begin
            state_d = TX_IDLE;
            shift_d = 8'h00;
          end
        end else begin
          bitIdx_d = bitIdx_q + 6'd1;
          if (bitIdx_q[2:0] == 3'd7) begin
            loadByte = 1'b1;
          end
        end
      end
      default: begin
        state_d  = TX_IDLE;
        bitIdx_d = '0;
        shift_d  = 8'h00;
      end
    endcase

    if (loadHead) begin
      nextByte = HEAD_PATTERN;
    end else if (loadByte) begin
      consume    = holdValid;
      nextByte   = holdValid ? holdData : FILL_BYTE;
      underrun_d = !holdValid;
    end

    if (loadHead || loadByte) begin
      dataOut_d = nextByte[7];
      shift_d   = {nextByte[6:0], 1'b0};
    end else if (state_d != TX_IDLE) begin
      dataOut_d = shift_q[7];
      shift_d   = {shift_q[6:0], 1'b0};
    end
  end

  // Registered framer state; reset aborts any frame without counting it
  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      state_q      <= TX_IDLE;
      bitIdx_q     <= '0;
      shift_q      <= 8'h00;
      dataOut_q    <= 1'b0;
      frameStart_q <= 1'b0;
      underrun_q   <= 1'b0;
      frameCnt_q   <= 16'h0000;
    end else begin
      state_q      <= state_d;
      bitIdx_q     <= bitIdx_d;
      shift_q      <= shift_d;
      dataOut_q    <= dataOut_d;
      frameStart_q <= frameStart_d;
      underrun_q   <= underrun_d;
      frameCnt_q   <= frameCnt_d;
    end
  end

  assign data_out    = dataOut_q;
  assign bit_index   = bitIdx_q;
  assign frame_start = frameStart_q;
  assign underrun    = underrun_q;
  assign tx_state    = state_q;
  assign frame_cnt   = frameCnt_q;

endmodule

// File: tb/tb_frame_head_inserter.sv
// Randomised scoreboard bench for frame_head_inserter. A frame-level model
// predicts every output cycle; a negedge monitor compares the DUT to it.
module tb_frame_head_inserter;

  logic        clk_out = 1'b0;
  logic        rst;
  logic        enable;
  logic [7:0]  din;
  logic        din_valid;
  logic        din_ready;
  logic        data_out;
  logic [5:0]  bit_index;
  logic        frame_start;
  logic        underrun;
  logic [1:0]  tx_state;
  logic [15:0] frame_cnt;

  frame_head_inserter dut (
    .clk_out     (clk_out),
    .rst         (rst),
    .enable      (enable),
    .din         (din),
    .din_valid   (din_valid),
    .din_ready   (din_ready),
    .data_out    (data_out),
    .bit_index   (bit_index),
    .frame_start (frame_start),
    .underrun    (underrun),
    .tx_state    (tx_state),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk_out = ~clk_out;

  typedef struct packed {
    logic        dataOut;
    logic [5:0]  idx;
    logic        fs;
    logic        ur;
    logic [1:0]  st;
    logic [15:0] cnt;
    logic        rdy;
  } exp_t;

  exp_t       expQ[$];
  int         checkCount = 0;
  int         passCount  = 0;

  // Reference model state: frame position, held bytes, bytes of the frame
  logic [7:0] headPat = 8'b01111110;
  logic [7:0] fillByte = 8'h00;
  bit         mActive = 1'b0;
  int         mK = 0;
  logic [15:0] mCnt = 16'h0;
  logic [7:0] holdQ[$];
  logic [7:0] mFrame[7];
  bit         mRdy = 1'b1;
  bit         streamMode = 1'b0;
  logic [7:0] streamByte = 8'h01;
  int         underrunSeen = 0;

  task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] required);
    checkCount++;
    if (actual === required) passCount++;
    else $display("[TB] FAIL %s: actual=%h required=%h at t=%0t", name, actual, required, $time);
  endtask

  task automatic applyStimulus(input bit en, input bit v, input logic [7:0] d);
    @(negedge clk_out);
    #1;
    enable    = en;
    din_valid = v;
    din       = d;
  endtask

  task automatic applyReset(input int cycles);
    @(negedge clk_out);
    #1;
    rst = 1'b1;
    #1;
    checkValue("async_reset_outputs", {7'd0, data_out, bit_index, frame_start, underrun, tx_state, frame_cnt}, 32'd0);
    repeat (cycles) @(negedge clk_out);
    #1;
    rst = 1'b0;
  endtask

  // Model: advance one bit per edge following the frame rules
  always @(posedge clk_out) begin
    exp_t e;
    bit   acc;
    bit   fs;
    bit   ur;
    int   j;
    fs = 1'b0;
    ur = 1'b0;
    if (rst) begin
      mActive = 1'b0;
      mK      = 0;
      mCnt    = 16'h0;
      holdQ.delete();
      mRdy    = 1'b1;
    end else begin
      acc = din_valid && mRdy;
      if (!mActive) begin
        if (enable) begin
          mActive = 1'b1;
          mK      = 0;
          fs      = 1'b1;
        end
      end else if (mK == 63) begin
        mCnt = mCnt + 16'd1;
        if (enable) begin
          mK = 0;
          fs = 1'b1;
        end else begin
          mActive = 1'b0;
          mK      = 0;
        end
      end else begin
        mK++;
      end
      if (mActive && mK >= 8 && ((mK - 8) % 8) == 0) begin
        j = (mK - 8) / 8;
        if (holdQ.size() > 0) mFrame[j] = holdQ.pop_front();
        else begin
          mFrame[j] = fillByte;
          ur = 1'b1;
          underrunSeen++;
        end
      end
      if (acc) begin
        holdQ.push_back(din);
        if (streamMode) streamByte = streamByte + 8'd1;
      end
      mRdy = (holdQ.size() == 0) ||
             (mActive && mK != 63 && (mK + 1) >= 8 && ((mK + 1 - 8) % 8) == 0);
    end
    e.fs  = fs;
    e.ur  = ur;
    e.cnt = mCnt;
    e.rdy = mRdy;
    e.idx = mActive ? 6'(mK) : 6'd0;
    if (!mActive) begin
      e.dataOut = 1'b0;
      e.st      = 2'b00;
    end else if (mK < 8) begin
      e.dataOut = headPat[7 - mK];
      e.st      = 2'b01;
    end else begin
      e.dataOut = mFrame[(mK - 8) / 8][7 - ((mK - 8) % 8)];
      e.st      = 2'b10;
    end
    expQ.push_back(e);
  end

  // Monitor: compare DUT outputs to the oldest prediction
  always @(negedge clk_out) begin
    exp_t e;
    if (expQ.size() == 0) begin
      checkValue("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = expQ.pop_front();
      checkValue("outputs{data,idx,fs,ur,st,cnt,rdy}",
                 {4'd0, data_out, bit_index, frame_start, underrun, tx_state, frame_cnt, din_ready},
                 {4'd0, e});
    end
  end

  initial begin
    int n;
    rst       = 1'b1;
    enable    = 1'b0;
    din_valid = 1'b0;
    din       = 8'h00;
    repeat (3) @(negedge clk_out);
    #1 rst = 1'b0;

    repeat (20) applyStimulus(1'b0, 1'b0, 8'h00);
    checkValue("idle_after_reset", {15'd0, data_out, tx_state, frame_cnt}, 32'd0);

    // Pre-filled 0xA5 followed by empty hold: underruns on later slots
    applyStimulus(1'b0, 1'b1, 8'hA5);
    repeat (64) applyStimulus(1'b1, 1'b0, 8'h00);
    // A frame with no data at all
    repeat (64) applyStimulus(1'b1, 1'b0, 8'h00);

    // Continuous stream of incrementing bytes, valid held high
    streamMode = 1'b1;
    repeat (140) applyStimulus(1'b1, 1'b1, streamByte);
    streamMode = 1'b0;

    // Drop enable at k=30; frame must run to completion then go idle
    n = 0;
    while (!(mActive && mK == 30) && n < 200) begin
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), 8'($urandom));
      n++;
    end
    checkValue("reach_k30", 32'(n < 200), 32'd1);
    repeat (80) applyStimulus(1'b0, 1'b0, 8'h00);
    checkValue("idle_after_drop", {30'd0, tx_state}, 32'd0);

    // Reset asserted mid-frame at k=20
    n = 0;
    while (!(mActive && mK == 20) && n < 200) begin
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), 8'($urandom));
      n++;
    end
    checkValue("reach_k20", 32'(n < 200), 32'd1);
    applyReset(2);

    // Randomised traffic, including head-like 0x7E payload bytes
    repeat (1500) begin
      applyStimulus(($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0) ? 8'h7E : 8'($urandom));
    end
    repeat (2) applyStimulus(1'b0, 1'b0, 8'h00);

    checkValue("underruns_observed", 32'(underrunSeen >= 7), 32'd1);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
